// File: rtl/vga_glyph_writer.sv
// Draws one 8x8 glyph into the 160x120 column-major VGA draw frame.
// A row bitmap is fetched from a registered font ROM, then emitted as one
// pixel per cycle on the frame write port.
// Ports:
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_start               draw request, sampled only when idle
//   i_char_code           glyph index
//   i_glyph_x, i_glyph_y  top-left corner in virtual pixels
//   i_fg_color/bg_color   RGB for '1' / '0' glyph bits
//   i_transparent_bg      suppress writes of '0' bits
//   o_busy, o_done        glyph in progress / one-cycle completion pulse
//   o_font_rom_addr       {char_code, row}; i_font_rom_row valid one cycle later
//   o_wr_mem_address/data/o_wr_a_pixel  frame write port
module vga_glyph_writer #(
    parameter int unsigned VIRTUAL_PIXEL_WIDTH  = 160,
    parameter int unsigned VIRTUAL_PIXEL_HEIGHT = 120,
    parameter int unsigned GLYPH_SIZE           = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [6:0]  i_char_code,
    input  logic [7:0]  i_glyph_x,
    input  logic [6:0]  i_glyph_y,
    input  logic [23:0] i_fg_color,
    input  logic [23:0] i_bg_color,
    input  logic        i_transparent_bg,
    output logic        o_busy,
    output logic        o_done,
    output logic [9:0]  o_font_rom_addr,
    input  logic [7:0]  i_font_rom_row,
    output logic [14:0] o_wr_mem_address,
    output logic [23:0] o_wr_mem_data,
    output logic        o_wr_a_pixel
);

    localparam logic [2:0] LAST_IDX = 3'(GLYPH_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DRAW,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_row;
    logic [2:0]  r_col;
    logic [7:0]  r_shift;
    logic [6:0]  r_code;
    logic [7:0]  r_gx;
    logic [6:0]  r_gy;
    logic [23:0] r_fg;
    logic [23:0] r_bg;
    logic        r_transp;

    logic        r_busy;
    logic        r_done;
    logic [9:0]  r_rom_addr;
    logic        r_wr;
    logic [14:0] r_addr;
    logic [23:0] r_data;

    state_t      w_state_nxt;
    logic [2:0]  w_row_nxt;
    logic [2:0]  w_col_nxt;
    logic [7:0]  w_shift_nxt;
    logic [6:0]  w_code_nxt;
    logic [9:0]  w_rom_addr_nxt;
    logic        w_bit;
    logic [8:0]  w_px;
    logic [7:0]  w_py;
    logic        w_in_frame;
    logic        w_wr_nxt;
    logic [14:0] w_addr;
    logic [23:0] w_data;

    // Next state plus next-cycle outputs; all outputs are registered from these.
    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_shift_nxt    = r_shift;
        w_code_nxt     = r_code;
        w_rom_addr_nxt = r_rom_addr;

        case (r_state)
            S_IDLE: begin
                w_code_nxt = i_char_code;
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_row_nxt   = 3'd0;
                    w_col_nxt   = 3'd0;
                end
            end
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_state_nxt = S_DRAW;
                w_shift_nxt = i_font_rom_row;
                w_col_nxt   = 3'd0;
            end
            S_DRAW: begin
                if (r_col == LAST_IDX) begin
                    if (r_row == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_row_nxt   = r_row + 3'd1;
                    end
                end else begin
                    w_col_nxt = r_col + 3'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt == S_FETCH) begin
            w_rom_addr_nxt = {w_code_nxt, w_row_nxt};
        end

        // Pixel for the upcoming DRAW cycle; column 0 is the row's MSB.
        w_bit      = w_shift_nxt[3'd7 - w_col_nxt];
        w_px       = 9'(r_gx) + 9'(w_col_nxt);
        w_py       = 8'(r_gy) + 8'(w_row_nxt);
        w_in_frame = (w_px < 9'(VIRTUAL_PIXEL_WIDTH)) && (w_py < 8'(VIRTUAL_PIXEL_HEIGHT));
        w_wr_nxt   = (w_state_nxt == S_DRAW) && w_in_frame && (w_bit || !r_transp);
        w_addr     = 15'(w_px) * 15'(VIRTUAL_PIXEL_HEIGHT) + 15'(w_py);
        w_data     = w_bit ? r_fg : r_bg;
    end

    // State, counters, latched request and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_row      <= 3'd0;
            r_col      <= 3'd0;
            r_shift    <= 8'd0;
            r_code     <= 7'd0;
            r_gx       <= 8'd0;
            r_gy       <= 7'd0;
            r_fg       <= 24'd0;
            r_bg       <= 24'd0;
            r_transp   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rom_addr <= 10'd0;
            r_wr       <= 1'b0;
            r_addr     <= 15'd0;
            r_data     <= 24'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_shift    <= w_shift_nxt;
            r_code     <= w_code_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_gx     <= i_glyph_x;
                r_gy     <= i_glyph_y;
                r_fg     <= i_fg_color;
                r_bg     <= i_bg_color;
                r_transp <= i_transparent_bg;
            end
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            r_rom_addr <= w_rom_addr_nxt;
            r_wr       <= w_wr_nxt;
            // Address/data only move on real writes, so they never leave the frame.
            if (w_wr_nxt) begin
                r_addr <= w_addr;
                r_data <= w_data;
            end
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_font_rom_addr  = r_rom_addr;
    assign o_wr_a_pixel     = r_wr;
    assign o_wr_mem_address = r_addr;
    assign o_wr_mem_data    = r_data;

endmodule
